// File: rtl/cacheline_adaptor.sv
// Bridges one 256-bit cacheline request from the L1 arbiter to a 4-beat,
// 64-bit burst on physical memory, returning the line and a completion pulse.
module cacheline_adaptor #(
    parameter int BEAT_WIDTH  = 64,
    parameter int BEATS       = 4,
    parameter int OFFSET_BITS = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BEATS*BEAT_WIDTH-1:0]   line_i,
    input  logic [31:0]                   address_i,
    input  logic                          read_i,
    input  logic                          write_i,
    output logic [BEATS*BEAT_WIDTH-1:0]   line_o,
    output logic                          resp_o,
    input  logic [BEAT_WIDTH-1:0]         burst_i,
    output logic [BEAT_WIDTH-1:0]         burst_o,
    output logic [31:0]                   address_o,
    output logic                          read_o,
    output logic                          write_o,
    input  logic                          resp_i
);

    localparam int LINE_WIDTH = BEATS * BEAT_WIDTH;
    localparam int CNT_W      = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [LINE_WIDTH-1:0]   line_q;
    logic [LINE_WIDTH-1:0]   line_out_q;
    logic [LINE_WIDTH-1:0]   captured;
    logic [31:0]             addr_q;
    logic [31:0]             aligned;
    logic                    last_beat;

    assign aligned   = {address_i[31:OFFSET_BITS], OFFSET_BITS'(0)};
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        captured = line_q;
        captured[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = burst_i;
        case (state_q)
            IDLE:    if (write_i)     state_d = WRITE;
                     else if (read_i) state_d = READ;
            READ:    if (resp_i && last_beat) state_d = DONE;
            WRITE:   if (resp_i && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            line_q     <= '0;
            line_out_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (write_i) begin
                        line_q <= line_i;
                        addr_q <= aligned;
                        cnt_q  <= '0;
                    end else if (read_i) begin
                        addr_q <= aligned;
                        cnt_q  <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_q <= captured;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        // line_o is separate so a later write cannot disturb the last read line.
                        if (last_beat) line_out_q <= captured;
                    end
                end
                WRITE: begin
                    if (resp_i) cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == DONE);
    assign address_o = addr_q;
    assign line_o    = line_out_q;
    assign burst_o   = (state_q == WRITE) ? line_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: read, stalled write, priority,
// mid-burst reset, back-to-back and request-change cases.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;
    localparam logic [63:0] Y0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] Y1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] Y2 = 64'h5A5A_5A5A_A5A5_A5A5;
    localparam logic [63:0] Y3 = 64'h0F0F_F0F0_0F0F_F0F0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        tick(); tick();
        check("rst_read_o",    256'(read_o),    256'(0));
        check("rst_write_o",   256'(write_o),   256'(0));
        check("rst_resp_o",    256'(resp_o),    256'(0));
        check("rst_line_o",    line_o,          256'(0));
        check("rst_burst_o",   256'(burst_o),   256'(0));
        check("rst_address_o", 256'(address_o), 256'(0));
        rst = 1'b0;
        tick();

        // Read, no stalls; address_i changes during beat 1
        read_i = 1'b1; address_i = 32'h1234_5678;                  // cycle 0
        tick();                                                    // cycle 1
        check("rd_read_o",  256'(read_o),    256'(1));
        check("rd_addr_c1", 256'(address_o), 256'(32'h1234_5660));
        resp_i = 1'b1; burst_i = B1;
        tick();                                                    // cycle 2
        burst_i = B2; address_i = 32'hFFFF_FFE0;
        tick();                                                    // cycle 3
        check("rd_addr_hold", 256'(address_o), 256'(32'h1234_5660));
        check("rd_resp_mid",  256'(resp_o),    256'(0));
        burst_i = B3;
        tick();                                                    // cycle 4
        check("rd_read_o_c4", 256'(read_o),    256'(1));
        check("rd_addr_c4",   256'(address_o), 256'(32'h1234_5660));
        burst_i = B4;
        tick();                                                    // cycle 5
        check("rd_resp_o", 256'(resp_o), 256'(1));
        check("rd_read_lo", 256'(read_o), 256'(0));
        check("rd_line_o", line_o, {B4, B3, B2, B1});
        resp_i = 1'b0; read_i = 1'b0;
        tick();                                                    // cycle 6

        // Back-to-back write with stalls
        check("b2b_resp_lo", 256'(resp_o), 256'(0));
        check("b2b_idle_rd", 256'(read_o), 256'(0));
        write_i = 1'b1; line_i = {WA, WB, WC, WD}; address_i = 32'h0000_ABCD;
        tick();                                                    // cycle 7
        check("wr_write_o", 256'(write_o), 256'(1));
        check("wr_no_rd",   256'(read_o),  256'(0));
        check("wr_addr",    256'(address_o), 256'(32'h0000_ABC0));
        check("wr_beat0",   256'(burst_o), 256'(WD));
        resp_i = 1'b1;
        tick();                                                    // cycle 8
        check("wr_beat1_a", 256'(burst_o), 256'(WC));
        resp_i = 1'b0;
        tick();                                                    // cycle 9
        check("wr_beat1_b", 256'(burst_o), 256'(WC));
        check("wr_stall_wo", 256'(write_o), 256'(1));
        tick();                                                    // cycle 10
        check("wr_beat1_c", 256'(burst_o), 256'(WC));
        resp_i = 1'b1;
        tick();                                                    // cycle 11
        check("wr_beat2", 256'(burst_o), 256'(WB));
        tick();                                                    // cycle 12
        check("wr_beat3", 256'(burst_o), 256'(WA));
        check("wr_resp_lo", 256'(resp_o), 256'(0));
        tick();                                                    // cycle 13
        check("wr_resp_o",   256'(resp_o),  256'(1));
        check("wr_write_lo", 256'(write_o), 256'(0));
        check("wr_line_o_kept", line_o, {B4, B3, B2, B1});
        resp_i = 1'b0; write_i = 1'b0;
        tick();                                                    // cycle 14
        check("wr_single_resp", 256'(resp_o), 256'(0));

        // Simultaneous read and write: write wins
        read_i = 1'b1; write_i = 1'b1; line_i = {Y3, Y2, Y1, Y0}; address_i = 32'h8000_003F;
        tick();
        check("pri_write_o", 256'(write_o), 256'(1));
        check("pri_read_o",  256'(read_o),  256'(0));
        check("pri_addr",    256'(address_o), 256'(32'h8000_0020));
        check("pri_beat0",   256'(burst_o), 256'(Y0));
        resp_i = 1'b1;
        tick(); tick(); tick();
        check("pri_beat3", 256'(burst_o), 256'(Y3));
        tick();
        check("pri_resp_o", 256'(resp_o), 256'(1));
        resp_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
        tick();

        // Reset after two read beats, then a fresh read with read_i held
        read_i = 1'b1; address_i = 32'h0000_1047;
        tick();
        check("rr_read_o", 256'(read_o), 256'(1));
        resp_i = 1'b1; burst_i = B1;
        tick();
        burst_i = B2;
        tick();
        rst = 1'b1; resp_i = 1'b0;
        tick();
        check("rr_read_lo", 256'(read_o),    256'(0));
        check("rr_resp_lo", 256'(resp_o),    256'(0));
        check("rr_addr_0",  256'(address_o), 256'(0));
        check("rr_line_0",  line_o,          256'(0));
        rst = 1'b0;
        tick();
        check("rr_restart", 256'(read_o),    256'(1));
        check("rr_addr",    256'(address_o), 256'(32'h0000_1040));
        resp_i = 1'b1; burst_i = Y0;
        tick();
        burst_i = Y1;
        tick();
        burst_i = Y2;
        tick();
        burst_i = Y3;
        check("rr_no_early_resp", 256'(resp_o), 256'(0));
        tick();
        check("rr_resp_o", 256'(resp_o), 256'(1));
        check("rr_line_o", line_o, {Y3, Y2, Y1, Y0});
        resp_i = 1'b0; read_i = 1'b0;
        tick();
        check("rr_idle", 256'(resp_o | read_o | write_o), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the L1 arbiter.
- Takes the arbiter's single 256-bit cacheline read or write request (arb_mem_read / arb_mem_write / arb_pmem_addr / arb_wdata).
- Converts it into a 4-beat, 64-bit burst transaction on the physical-memory interface.
- Returns the assembled line and a one-cycle completion pulse, which drive the arbiter's l2_rdata / l2_resp inputs.

Parameters:
- BEAT_WIDTH, 64: width of one memory burst beat in bits.
- BEATS, 4: beats per cacheline. Line width is BEATS*BEAT_WIDTH = 256.
- OFFSET_BITS, 5: low address bits cleared to line-align the memory address.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- line_i  in  256  write line from the arbiter (arb_wdata).
- address_i  in  32  request address from the arbiter (arb_pmem_addr).
- read_i  in  1  line read request; held until resp_o.
- write_i  in  1  line write request; held until resp_o.
- line_o  out  256  assembled read line; valid when resp_o=1 for a read.
- resp_o  out  1  one-cycle completion pulse for a read or write.
- burst_i  in  64  read beat from memory; valid when resp_i=1 during a read.
- burst_o  out  64  current write beat to memory.
- address_o  out  32  line-aligned memory address.
- read_o  out  1  memory burst read request.
- write_o  out  1  memory burst write request.
- resp_i  in  1  memory beat strobe; one beat transferred per cycle while high.

Behaviour:
- States: IDLE, READ, WRITE, DONE. All outputs are registered or decoded from state/registers only; no combinational path from any input to any output.
- Reset (rst=1 at an edge, from any state, including mid-burst):
  - Next state is IDLE; beat counter 0.
  - read_o=0, write_o=0, resp_o=0.
  - line_o=0, burst_o=0, address_o=0.
  - A burst in flight is abandoned; no resp_o is generated for it.
- IDLE:
  - write_i=1: latch line_i into the line buffer and {address_i[31:5],5'b0} into the address register; counter=0; go to WRITE.
  - Else read_i=1: latch the aligned address; counter=0; go to READ.
  - If both are high, write has priority. This is illegal from the arbiter but defined here.
  - resp_i is ignored in IDLE and DONE.
- READ:
  - read_o=1; address_o holds the latched address.
  - On each cycle with resp_i=1: line buffer slice [64*cnt +: 64] is loaded from burst_i, then cnt increments.
  - resp_i low cycles are stalls: no capture, no increment, read_o stays high.
  - The cycle that captures beat 3 moves to DONE. read_o drops in the following cycle.
- WRITE:
  - write_o=1; burst_o = line buffer slice [64*cnt +: 64].
  - Each cycle with resp_i=1 consumes the current beat and increments cnt.
  - Stalls behave as in READ.
  - Consuming beat 3 moves to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=0, write_o=0.
  - line_o presents the line buffer. line_o holds its value until the next read completes.
  - Next state is IDLE.
  - The requester drops its request in the cycle after resp_o. A request still high in the IDLE cycle after DONE is treated as a new request.
- Beat order and widths:
  - Beat 0 is bits [63:0], ascending to beat 3 = [255:192].
  - The counter is 2 bits and does not wrap within a transaction; it is reset on entry to READ and WRITE.
- Request stability: address_i, line_i, read_i and write_i changing mid-burst have no effect, because the latched copies are used.
- Latency:
  - Request seen in IDLE at cycle 0; read_o/write_o high from cycle 1.
  - With resp_i high on cycles k..k+3, resp_o is high on cycle k+4.
  - Minimum request-to-resp_o is 5 cycles (k=1).

Test Plan:
- Read, no stalls: read_i=1, address_i=0x1234_5678; memory gives resp_i cycles 1-4 with beats 0x1111..., 0x2222..., 0x3333..., 0x4444... → address_o=0x1234_5660 while read_o=1; resp_o pulses once at cycle 5; line_o={0x4444..,0x3333..,0x2222..,0x1111..}.
- Write with stall: line_i=0xAAAA...BBBB...CCCC...DDDD (beat3..beat0), resp_i pattern 1,0,0,1,1,1 → burst_o sequence DDDD, CCCC (held 3 cycles), BBBB, AAAA; write_o high throughout; resp_o one cycle after the final beat.
- Simultaneous read_i=1 and write_i=1 in IDLE → WRITE is taken; write_o=1, read_o stays 0.
- Reset mid-read after 2 beats (rst=1 for one cycle) → next cycle read_o=0, resp_o=0, state IDLE; with read_i still high, a fresh read restarts at beat 0 and completes normally.
- Back-to-back: a read completes, then write_i is raised the cycle after resp_o → write_o is asserted at the next cycle, never overlapping read_o, and one resp_o is produced per transaction.
- Request input change mid-burst: address_i changed to 0xFFFF_FFE0 during beat 1 → address_o is unchanged until DONE.
